// File: rtl/odo_round_key_sequencer.sv
// Round-key sequencer: issues period indices to the key ROM and XORs the returned keys into a multi-lane state.
// Optional macro ODO_ROUND_KEY_SUM_EN adds a key_sum output with the XOR of every applied key.
module odo_round_key_sequencer #(
  parameter int LANES       = 6,
  parameter int NUM_PERIODS = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  input  logic [10*LANES-1:0]   state_in,
  output logic [3:0]            period,
  input  logic [9:0]            key,
  output logic [10*LANES-1:0]   state_out,
  output logic                  done
`ifdef ODO_ROUND_KEY_SUM_EN
  ,
  output logic [9:0]            key_sum
`endif
);

  // Handshake: start is taken only on a cycle where ready=1; done pulses for one
  // cycle with state_out valid, and state_out holds until the next accepted start.
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t                  fsm;
  logic [4:0]            issue_cnt;
  logic [LW-1:0]         lane_cnt;
  logic                  v;
  logic                  v_d;
  logic [3:0]            pd;
  logic [10*LANES-1:0]   lanes_q;
  logic [10*LANES-1:0]   lanes_next;
  logic                  final_key;

  // pd/v_d line up with the ROM's one-cycle latency, so key is only looked at when v_d=1.
  assign final_key = v_d && (pd == 4'(NUM_PERIODS - 1));

  always_comb begin
    lanes_next = lanes_q;
    if (v_d) begin
      lanes_next[10*int'(lane_cnt) +: 10] = lanes_q[10*int'(lane_cnt) +: 10] ^ key;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      period    <= 4'h0;
      state_out <= '0;
      issue_cnt <= '0;
      lane_cnt  <= '0;
      v         <= 1'b0;
      v_d       <= 1'b0;
      pd        <= 4'h0;
      lanes_q   <= '0;
`ifdef ODO_ROUND_KEY_SUM_EN
      key_sum   <= 10'h000;
`endif
    end else begin
      pd  <= period;
      v_d <= v;
      case (fsm)
        IDLE: begin
          v <= 1'b0;
          if (start) begin
            lanes_q   <= state_in;
            period    <= 4'h0;
            issue_cnt <= 5'd1;
            v         <= 1'b1;
            lane_cnt  <= '0;
            ready     <= 1'b0;
            fsm       <= RUN;
`ifdef ODO_ROUND_KEY_SUM_EN
            key_sum   <= 10'h000;
`endif
          end
        end
        RUN: begin
          if (issue_cnt < 5'(NUM_PERIODS)) begin
            period    <= issue_cnt[3:0];
            issue_cnt <= issue_cnt + 5'd1;
            v         <= 1'b1;
          end else begin
            v <= 1'b0;
          end
          if (v_d) begin
            lanes_q  <= lanes_next;
            lane_cnt <= (lane_cnt == LW'(LANES - 1)) ? '0 : lane_cnt + LW'(1);
`ifdef ODO_ROUND_KEY_SUM_EN
            key_sum  <= key_sum ^ key;
`endif
          end
          if (final_key) begin
            state_out <= lanes_next;
            done      <= 1'b1;
            fsm       <= DONE;
          end
        end
        DONE: begin
          v     <= 1'b0;
          done  <= 1'b0;
          ready <= 1'b1;
          fsm   <= IDLE;
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_odo_round_key_sequencer.sv
// Bench for odo_round_key_sequencer: a default instance (6 lanes, 9 periods) and a 1-lane/1-period instance,
// each fed by a registered key ROM model.
module tb_odo_round_key_sequencer;

  localparam int NA = 9;
  localparam int LA = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, ready_a, done_a;
  logic [59:0] state_in_a, state_out_a;
  logic [3:0]  period_a;
  logic [9:0]  key_a;

  logic        start_b, ready_b, done_b;
  logic [9:0]  state_in_b, state_out_b;
  logic [3:0]  period_b;
  logic [9:0]  key_b;

`ifdef ODO_ROUND_KEY_SUM_EN
  logic [9:0]  key_sum_a, key_sum_b;
`endif

  odo_round_key_sequencer #(.LANES(LA), .NUM_PERIODS(NA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ready(ready_a), .state_in(state_in_a),
    .period(period_a), .key(key_a), .state_out(state_out_a), .done(done_a)
`ifdef ODO_ROUND_KEY_SUM_EN
    , .key_sum(key_sum_a)
`endif
  );

  odo_round_key_sequencer #(.LANES(1), .NUM_PERIODS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ready(ready_b), .state_in(state_in_b),
    .period(period_b), .key(key_b), .state_out(state_out_b), .done(done_b)
`ifdef ODO_ROUND_KEY_SUM_EN
    , .key_sum(key_sum_b)
`endif
  );

  function automatic logic [9:0] rom_key(input logic [3:0] p);
    case (p)
      4'd0:    return 10'h2d1;
      4'd1:    return 10'h081;
      4'd2:    return 10'h0fd;
      4'd3:    return 10'h080;
      4'd4:    return 10'h1c4;
      4'd5:    return 10'h1d6;
      4'd6:    return 10'h2cf;
      4'd7:    return 10'h25d;
      4'd8:    return 10'h083;
      default: return 10'bx;
    endcase
  endfunction

  // Registered ROM; drives X while the block is idle so stray key sampling shows up.
  always @(posedge clk) begin
    key_a <= ready_a ? 10'bx : rom_key(period_a);
    key_b <= ready_b ? 10'bx : rom_key(period_b);
  end

  function automatic logic [59:0] model_a(input logic [59:0] s);
    logic [59:0] r;
    r = s;
    for (int p = 0; p < NA; p++) r[10*(p%LA) +: 10] = r[10*(p%LA) +: 10] ^ rom_key(4'(p));
    return r;
  endfunction

  int errors = 0;
  int checks = 0;
  int done_cnt_a = 0;
  logic [59:0] exp_q_a[$];
  logic [9:0]  exp_q_b[$];

  always @(negedge clk) if (done_a === 1'b1) done_cnt_a++;

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic run_job_a(input logic [59:0] s, input bit busy);
    logic [59:0] exp;
    logic [3:0]  exp_p;
    int          base;
    @(negedge clk);
    checks++;
    if (ready_a !== 1'b1) begin errors++; $display("FAIL ready_before_start_a got=%b exp=1", ready_a); end
    state_in_a = s;
    start_a = 1'b1;
    exp_q_a.push_back(model_a(s));
    base = done_cnt_a;
    for (int cyc = 0; cyc <= NA + 2; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      state_in_a = 60'({$urandom(), $urandom()});
      if (cyc <= NA + 1) begin
        exp_p = (cyc < NA) ? 4'(cyc) : 4'(NA - 1);
        checks++;
        if (period_a !== exp_p) begin errors++; $display("FAIL period_a cyc=%0d got=%h exp=%h", cyc, period_a, exp_p); end
      end
      checks++;
      if (done_a !== (cyc == NA + 1)) begin errors++; $display("FAIL done_a cyc=%0d got=%b exp=%b", cyc, done_a, (cyc == NA + 1)); end
      checks++;
      if (ready_a !== (cyc == NA + 2)) begin errors++; $display("FAIL ready_a cyc=%0d got=%b exp=%b", cyc, ready_a, (cyc == NA + 2)); end
      if (cyc == NA + 1) begin
        checks++;
        if (exp_q_a.size() == 0) begin
          errors++; $display("FAIL state_out_a scoreboard empty got=%h", state_out_a);
        end else begin
          exp = exp_q_a.pop_front();
          if (state_out_a !== exp) begin errors++; $display("FAIL state_out_a got=%h exp=%h", state_out_a, exp); end
        end
      end
      if (busy && (cyc == 2 || cyc == NA + 1)) start_a = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (ready_a !== 1'b1) begin errors++; $display("FAIL ready_after_job_a got=%b exp=1", ready_a); end
    checks++;
    if (done_cnt_a != base + 1) begin errors++; $display("FAIL done_count_a got=%0d exp=%0d", done_cnt_a - base, 1); end
  endtask

  // Caller must be at a negedge where ready_b is expected high; returns at such a negedge.
  task automatic run_job_b(input logic [9:0] s);
    logic [9:0] exp;
    checks++;
    if (ready_b !== 1'b1) begin errors++; $display("FAIL ready_before_start_b got=%b exp=1", ready_b); end
    state_in_b = s;
    start_b = 1'b1;
    exp_q_b.push_back(s ^ 10'h2d1);
    for (int cyc = 0; cyc <= 2; cyc++) begin
      @(negedge clk);
      start_b = 1'b0;
      state_in_b = 10'($urandom());
      checks++;
      if (period_b !== 4'h0) begin errors++; $display("FAIL period_b cyc=%0d got=%h exp=0", cyc, period_b); end
      checks++;
      if (done_b !== (cyc == 2)) begin errors++; $display("FAIL done_b cyc=%0d got=%b exp=%b", cyc, done_b, (cyc == 2)); end
      if (cyc == 2) begin
        checks++;
        if (exp_q_b.size() == 0) begin
          errors++; $display("FAIL state_out_b scoreboard empty got=%h", state_out_b);
        end else begin
          exp = exp_q_b.pop_front();
          if (state_out_b !== exp) begin errors++; $display("FAIL state_out_b got=%h exp=%h", state_out_b, exp); end
        end
      end
    end
    @(negedge clk);
    checks++;
    if (ready_b !== 1'b1 || done_b !== 1'b0) begin
      errors++; $display("FAIL ready_after_job_b ready=%b done=%b exp ready=1 done=0", ready_b, done_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    state_in_a = '0; state_in_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready_a !== 1'b1 || done_a !== 1'b0 || period_a !== 4'h0 || state_out_a !== 60'h0) begin
      errors++; $display("FAIL reset_a ready=%b done=%b period=%h state_out=%h exp 1/0/0/0", ready_a, done_a, period_a, state_out_a);
    end
    checks++;
    if (ready_b !== 1'b1 || done_b !== 1'b0 || period_b !== 4'h0 || state_out_b !== 10'h0) begin
      errors++; $display("FAIL reset_b ready=%b done=%b period=%h state_out=%h exp 1/0/0/0", ready_b, done_b, period_b, state_out_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    state_in_a = {6{10'h155}};
    start_a = 1'b1;
    for (int cyc = 0; cyc <= 4; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    checks++;
    if (period_a !== 4'h4) begin errors++; $display("FAIL period_before_mid_reset got=%h exp=4", period_a); end
    rst = 1'b1;
    #1;
    checks++;
    if (ready_a !== 1'b1 || done_a !== 1'b0 || period_a !== 4'h0 || state_out_a !== 60'h0) begin
      errors++; $display("FAIL mid_run_reset ready=%b done=%b period=%h state_out=%h exp 1/0/0/0", ready_a, done_a, period_a, state_out_a);
    end
    @(negedge clk);
    rst = 1'b0;
    run_job_a(60'h0, 1'b0);
  endtask

  task automatic test_basic();
    run_job_a(60'h0, 1'b0);
    run_job_a({6{10'h3ff}}, 1'b0);
  endtask

  task automatic test_busy_start();
    run_job_a(60'({$urandom(), $urandom()}), 1'b1);
  endtask

  task automatic test_random_jobs();
    for (int i = 0; i < 3; i++) run_job_a(60'({$urandom(), $urandom()}), ($urandom_range(0, 1) == 1));
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_job_b(10'h000);
    run_job_b(10'($urandom_range(0, 1023)));
    run_job_b(10'h3ff);
  endtask

`ifdef ODO_ROUND_KEY_SUM_EN
  task automatic test_key_sum();
    logic [9:0] exp_sum;
    exp_sum = 10'h000;
    for (int p = 0; p < NA; p++) exp_sum = exp_sum ^ rom_key(4'(p));
    run_job_a(60'({$urandom(), $urandom()}), 1'b0);
    checks++;
    if (key_sum_a !== exp_sum) begin errors++; $display("FAIL key_sum_a got=%h exp=%h", key_sum_a, exp_sum); end
    checks++;
    if (key_sum_b !== 10'h2d1) begin errors++; $display("FAIL key_sum_b got=%h exp=2d1", key_sum_b); end
    start_a = 1'b1;
    state_in_a = '0;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (key_sum_a !== 10'h000) begin errors++; $display("FAIL key_sum_clear got=%h exp=000", key_sum_a); end
    for (int cyc = 0; cyc < 40 && ready_a !== 1'b1; cyc++) @(negedge clk);
    checks++;
    if (ready_a !== 1'b1) begin errors++; $display("FAIL key_sum_job_timeout ready=%b exp=1", ready_a); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_run();
    test_basic();
    test_busy_start();
    test_random_jobs();
    test_back_to_back();
`ifdef ODO_ROUND_KEY_SUM_EN
    test_key_sum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
